lane_onehot_encoder: RTL and testbench



---
 rtl/lane_pkg.sv | 22 ++
 rtl/lane_onehot_encoder_if.sv | 13 +
 rtl/lane_hold_cnt.sv | 22 ++
 rtl/lane_onehot_encoder.sv | 112 +++++++++++
 tb/tb_lane_onehot_encoder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/lane_pkg.sv
// Shared types and widths for the one-hot lane encoder.
package lane_pkg;

    localparam int LANE_W    = 5;
    localparam int NUM_LANES = 4;
    localparam int IDX_W     = 2;
    localparam int CNT_W     = 4;
    localparam int TXCNT_W   = 8;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_e;

    typedef logic [NUM_LANES-1:0][LANE_W-1:0] lanes_t;

    function automatic lanes_t onehot_lanes(input logic [IDX_W-1:0]  idx,
                                            input logic [LANE_W-1:0] data);
        lanes_t l;
        l      = '0;
        l[idx] = data;
        return l;
    endfunction

endpackage

// File: rtl/lane_onehot_encoder_if.sv
// Request handshake carrying (lane index, payload) into the encoder.
interface lane_onehot_encoder_if;
    import lane_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [IDX_W-1:0]  in_idx;
    logic [LANE_W-1:0] in_data;

    modport master (output in_valid, in_idx, in_data, input in_ready);
    modport slave  (input in_valid, in_idx, in_data, output in_ready);

endinterface

// File: rtl/lane_hold_cnt.sv
// Loadable down-counter with zero flag; saturates at zero when not reloaded.
module lane_hold_cnt
    import lane_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lane_onehot_encoder.sv
// Drives one payload onto one of four lanes for HOLD_CYCLES, then a GAP_CYCLES idle gap.
// Optional build macro ZERO_GUARD_EN: zero payloads are consumed with an err pulse.
module lane_onehot_encoder
    import lane_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
)(
    input  logic                clk,
    input  logic                rst_n,
    lane_onehot_encoder_if.slave req,
    output logic [LANE_W-1:0]   a0,
    output logic [LANE_W-1:0]   a1,
    output logic [LANE_W-1:0]   a2,
    output logic [LANE_W-1:0]   a3,
    output logic                busy,
    output logic                err,
    output logic [TXCNT_W-1:0]  tx_count
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e           state, state_nxt;
    lanes_t           lane_q, lane_d;
    logic             accept, zero_rej, frame_go, done;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign accept = req.in_valid && req.in_ready;
`ifdef ZERO_GUARD_EN
    assign zero_rej = accept && (req.in_data == '0);
`else
    assign zero_rej = 1'b0;
`endif
    assign frame_go = accept && !zero_rej;
    assign done     = (state == DRIVE) && cnt_zero;

    // One counter serves both the hold and the gap phases.
    lane_hold_cnt u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_go) state_nxt = DRIVE;
            DRIVE:   if (cnt_zero) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (cnt_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req.in_ready = (state == IDLE);

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = HOLD_LOAD;
        lane_d   = '0;
        if (frame_go) begin
            cnt_load = 1'b1;
            lane_d   = onehot_lanes(req.in_idx, req.in_data);
        end else if ((state == DRIVE) && !cnt_zero) begin
            lane_d   = lane_q;
        end else if (done && (GAP_CYCLES > 0)) begin
            cnt_load = 1'b1;
            cnt_val  = GAP_LOAD;
        end
    end

    // Lane register doubles as the latch for the accepted index/payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q   <= '0;
            tx_count <= '0;
        end else begin
            lane_q <= lane_d;
            if (done) tx_count <= tx_count + 1'b1;
        end
    end

`ifdef ZERO_GUARD_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= zero_rej;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign a0 = lane_q[0];
    assign a1 = lane_q[1];
    assign a2 = lane_q[2];
    assign a3 = lane_q[3];

endmodule

// File: tb/tb_lane_onehot_encoder.sv
// Bench for lane_onehot_encoder: vector table, directed corner sequences, random traffic vs a frame-timing model.
module tb_lane_onehot_encoder;
    import lane_pkg::*;

    localparam int H = 2;
    localparam int G = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lane_onehot_encoder_if bus0 ();
    lane_onehot_encoder_if bus1 ();

    logic [4:0] x0, x1, x2, x3, y0, y1, y2, y3;
    logic       busy0, err0, busy1, err1;
    logic [7:0] tx0, tx1;

    lane_onehot_encoder #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .req(bus0),
        .a0(x0), .a1(x1), .a2(x2), .a3(x3),
        .busy(busy0), .err(err0), .tx_count(tx0)
    );

    lane_onehot_encoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_fast (
        .clk(clk), .rst_n(rst_n), .req(bus1),
        .a0(y0), .a1(y1), .a2(y2), .a3(y3),
        .busy(busy1), .err(err1), .tx_count(tx1)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: frame timing as arithmetic on the edge number of the accept.
    int         n = 0, start = -1000, free_at = 0, m_idx = 0, m_ncomp = 0;
    logic [4:0] m_data  = '0;
    logic [19:0] m_lanes = '0;
    logic       m_busy = 1'b0, m_err = 1'b0, m_ready = 1'b1;
    logic [7:0] m_tx = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start = -1000; free_at = 0; m_lanes = '0;
            m_busy = 1'b0; m_err = 1'b0; m_ready = 1'b1; m_tx = '0;
        end else begin
            n++;
            m_err = 1'b0;
            if (bus0.in_valid && m_ready) begin
`ifdef ZERO_GUARD_EN
                if (bus0.in_data == 5'd0) m_err = 1'b1;
                else
`endif
                begin
                    start   = n;
                    m_idx   = int'(bus0.in_idx);
                    m_data  = bus0.in_data;
                    free_at = n + H + G + 1;
                end
            end
            if (n == start + H) begin m_tx++; m_ncomp++; end
            m_lanes = (n >= start && n < start + H) ? (20'(m_data) << (5 * m_idx)) : 20'd0;
            m_busy  = (n >= start && n < start + H + G);
            m_ready = (n + 1 >= free_at);
        end
    end

    logic [7:0] prev_tx  = '0;
    bit         saw_wrap = 1'b0;

    always @(negedge clk) begin
        int nz;
        check("lanes",    32'({x3, x2, x1, x0}), 32'(m_lanes));
        check("busy",     32'(busy0),  32'(m_busy));
        check("in_ready", 32'(bus0.in_ready), 32'(m_ready));
        check("tx_count", 32'(tx0),    32'(m_tx));
        check("err",      32'(err0),   32'(m_err));
        nz = int'(x0 != 0) + int'(x1 != 0) + int'(x2 != 0) + int'(x3 != 0);
        check("onehot", 32'(nz <= 1), 32'd1);
        if (prev_tx == 8'd255 && tx0 == 8'd0) saw_wrap = 1'b1;
        prev_tx = tx0;
    end

    typedef struct {
        logic [1:0]  idx;
        logic [4:0]  data;
        logic [19:0] exp;
    } vec_t;
    vec_t tbl [5];

    task automatic wait_ready0();
        for (int t = 0; t < 20 && !bus0.in_ready; t++) @(negedge clk);
        if (!bus0.in_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int ncomp0;
        tbl[0] = '{2'd2, 5'b10110, 20'h05800};
        tbl[1] = '{2'd0, 5'd1,     20'h00001};
        tbl[2] = '{2'd1, 5'd2,     20'h00040};
        tbl[3] = '{2'd2, 5'd4,     20'h01000};
        tbl[4] = '{2'd3, 5'd8,     20'h40000};

        bus0.in_valid = 1'b0; bus0.in_idx = '0; bus0.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_idx = '0; bus1.in_data = '0;
        #23 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx0), 32'd0);
        check("rst_ready", 32'(bus0.in_ready), 32'd1);

        // Vector table, valid held high; inputs change right after each accept.
        for (int i = 0; i < 5; i++) begin
            bus0.in_idx = tbl[i].idx; bus0.in_data = tbl[i].data; bus0.in_valid = 1'b1;
            wait_ready0();
            @(posedge clk);
            @(negedge clk);
            check("tbl_lanes", 32'({x3, x2, x1, x0}), 32'(tbl[i].exp));
        end
        bus0.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("tbl_tx", 32'(tx0), 32'd5);

        // HOLD=1, GAP=0: back-to-back frames with exactly one idle cycle between.
        bus1.in_valid = 1'b1; bus1.in_idx = 2'd0; bus1.in_data = 5'd7;
        @(posedge clk); @(negedge clk);
        check("fast_f1", 32'({y3, y2, y1, y0}), 32'h00007);
        bus1.in_idx = 2'd3; bus1.in_data = 5'd9;
        @(negedge clk);
        check("fast_idle", 32'({y3, y2, y1, y0}), 32'h0);
        check("fast_ready", 32'(bus1.in_ready), 32'd1);
        @(negedge clk);
        check("fast_f2", 32'({y3, y2, y1, y0}), 32'h48000);
        bus1.in_valid = 1'b0;
        @(negedge clk);
        check("fast_end", 32'({y3, y2, y1, y0}), 32'h0);
        check("fast_tx", 32'(tx1), 32'd2);

        // Async reset during the second DRIVE cycle.
        bus0.in_valid = 1'b1; bus0.in_idx = 2'd2; bus0.in_data = 5'd21;
        wait_ready0();
        @(posedge clk); #1 bus0.in_valid = 1'b0;
        @(posedge clk); #2;
        check("pre_rst", 32'({x3, x2, x1, x0}), 32'h05400);
        rst_n = 1'b0;
        #1;
        check("rst_lanes", 32'({x3, x2, x1, x0}), 32'h0);
        check("rst_busy",  32'(busy0), 32'd0);
        check("rst_tx0",   32'(tx0),   32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus0.in_ready), 32'd1);

`ifdef ZERO_GUARD_EN
        bus0.in_valid = 1'b1; bus0.in_idx = 2'd1; bus0.in_data = 5'd0;
        @(posedge clk); @(negedge clk);
        bus0.in_valid = 1'b0;
        check("zg_err",   32'(err0), 32'd1);
        check("zg_lanes", 32'({x3, x2, x1, x0}), 32'h0);
        check("zg_ready", 32'(bus0.in_ready), 32'd1);
        check("zg_tx",    32'(tx0), 32'd0);
        @(negedge clk);
        check("zg_err_end", 32'(err0), 32'd0);
        bus0.in_valid = 1'b1; bus0.in_data = 5'd3;
        @(posedge clk); @(negedge clk);
        bus0.in_valid = 1'b0;
        check("zg_next", 32'({x3, x2, x1, x0}), 32'h00060);
`else
        bus0.in_valid = 1'b1; bus0.in_idx = 2'd1; bus0.in_data = 5'd0;
        @(posedge clk); @(negedge clk);
        bus0.in_valid = 1'b0;
        check("zero_busy",  32'(busy0), 32'd1);
        check("zero_lanes", 32'({x3, x2, x1, x0}), 32'h0);
        repeat (4) @(negedge clk);
        check("zero_tx", 32'(tx0), 32'd1);
`endif
        repeat (4) @(negedge clk);

        // Random traffic long enough to wrap the frame counter.
        ncomp0   = m_ncomp;
        saw_wrap = 1'b0;
        repeat (1500) begin
            @(negedge clk);
            bus0.in_valid = ($urandom_range(0, 9) != 0);
            bus0.in_idx   = 2'($urandom_range(0, 3));
            bus0.in_data  = 5'($urandom_range(0, 31));
        end
        bus0.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("frames_256", 32'((m_ncomp - ncomp0) >= 256), 32'd1);
        check("tx_wrap", 32'(saw_wrap), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
